// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and width,
// reused by every stage in the pipeline.
package pipe_pkg;
  localparam int OCC_W = 2;
  typedef logic [OCC_W-1:0] occ_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic occ_t occ_of(input pipe_state_e s);
    case (s)
      ST_BUSY: return occ_t'(1);
      ST_FULL: return occ_t'(2);
      default: return occ_t'(0);
    endcase
  endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid register: load has priority over hold, clr over load.
module pipe_skid_buf #(
  parameter int                 DATA_W   = 160,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RST_DATA;
    else if (clr)  q <= RST_DATA;
    else if (load) q <= d;
  end
endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional skid entry. Define
// PIPE_SKID_STAGE_SKID_EN for a 2-deep stage with registered in_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 160,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output occ_t              occupancy
);
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept, deliver;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] skid_q;

  // Decoded from the state register only: no path from out_ready.
  assign in_ready = (state_q != ST_FULL) & ~bubble & ~rst;

  pipe_skid_buf #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clr  (skid_clr),
    .d    (in_data),
    .q    (skid_q)
  );

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_d   = RST_DATA;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
        ST_BUSY: begin
          if (accept && deliver) main_d = in_data;
          else if (deliver)      state_d = ST_EMPTY;
          else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end
        end
        ST_FULL: if (deliver) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`else
  // Single-entry stage: accept only when the slot is free or draining.
  assign in_ready = (~out_valid | out_ready) & ~bubble & ~rst;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
        ST_BUSY: begin
          if (accept)       main_d = in_data;
          else if (deliver) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard bench for pipe_skid_stage; covers both
// PIPE_SKID_STAGE_SKID_EN settings.
module tb_pipe_skid_stage;
  localparam int DW = 160;
  localparam logic [DW-1:0] RST_V = 160'hA5A5_0000_0000_0000_0000_0000_0000_0000_0000_C3C3;

  logic          clk = 1'b0;
  logic          rst, flush, bubble, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .RST_DATA(RST_V)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; bubble = 1'b0; flush = 1'b0;
  endtask

  // Load one item into an empty stage and leave it held.
  task automatic load_one(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); in_data = '0;
    #12;
    tests++;
    if ({out_valid, occupancy, in_ready} !== {1'b0, 2'd0, 1'b0}) begin
      fails++; $display("FAIL reset_ctrl got v=%0b occ=%0d rdy=%0b exp 0 0 0", out_valid, occupancy, in_ready);
    end
    tests++;
    if (out_data !== RST_V) begin
      fails++; $display("FAIL reset_data got %h exp %h", out_data, RST_V);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_data = 160'h11; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL basic_in_ready got %0b exp 1", in_ready);
    end
    step(); in_valid = 1'b0;
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, 160'h11}) begin
      fails++; $display("FAIL basic_latency got v=%0b occ=%0d d=%h exp 1 1 11", out_valid, occupancy, out_data);
    end
    step();
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 160'h11}) begin
      fails++; $display("FAIL basic_drain_hold got v=%0b occ=%0d d=%h exp 0 0 11", out_valid, occupancy, out_data);
    end
    idle();
  endtask

  task automatic test_skid();
    load_one(160'h11);
    in_valid = 1'b1; in_data = 160'h22; out_ready = 1'b0;
`ifdef PIPE_SKID_STAGE_SKID_EN
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL skid_accept_rdy got %0b exp 1", in_ready);
    end
    step(); in_valid = 1'b0;
    tests++;
    if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 160'h11}) begin
      fails++; $display("FAIL skid_full got occ=%0d rdy=%0b d=%h exp 2 0 11", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, 160'h22}) begin
      fails++; $display("FAIL skid_second got v=%0b occ=%0d d=%h exp 1 1 22", out_valid, occupancy, out_data);
    end
    step();
    tests++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      fails++; $display("FAIL skid_drained got v=%0b occ=%0d exp 0 0", out_valid, occupancy);
    end
`else
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL noskid_stall_rdy got %0b exp 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL noskid_pass_rdy got %0b exp 1", in_ready);
    end
    step(); in_valid = 1'b0;
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, 160'h22}) begin
      fails++; $display("FAIL noskid_replace got v=%0b occ=%0d d=%h exp 1 1 22", out_valid, occupancy, out_data);
    end
    step();
    tests++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      fails++; $display("FAIL noskid_drained got v=%0b occ=%0d exp 0 0", out_valid, occupancy);
    end
`endif
    idle();
  endtask

  task automatic test_flush();
    load_one(160'h11);
`ifdef PIPE_SKID_STAGE_SKID_EN
    in_valid = 1'b1; in_data = 160'h22;
    step();
`endif
    in_valid = 1'b1; in_data = 160'h44; flush = 1'b1; out_ready = 1'b0;
    step();
    idle();
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, RST_V}) begin
      fails++; $display("FAIL flush_clear got v=%0b occ=%0d d=%h exp 0 0 rst", out_valid, occupancy, out_data);
    end
    out_ready = 1'b1;
    step(); step();
    tests++;
    if ({out_valid, out_data} !== {1'b0, RST_V}) begin
      fails++; $display("FAIL flush_no_ghost got v=%0b d=%h exp 0 rst", out_valid, out_data);
    end
    idle();
  endtask

  task automatic test_bubble();
    load_one(160'h55);
    bubble = 1'b1; in_valid = 1'b1; in_data = 160'h66; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL bubble_rdy got %0b exp 0", in_ready);
    end
    step();
    idle();
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 160'h55}) begin
      fails++; $display("FAIL bubble_drain got v=%0b occ=%0d d=%h exp 0 0 55", out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_async_reset();
    load_one(160'h77);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, occupancy, in_ready, out_data} !== {1'b0, 2'd0, 1'b0, RST_V}) begin
      fails++; $display("FAIL async_rst got v=%0b occ=%0d rdy=%0b d=%h exp 0 0 0 rst", out_valid, occupancy, in_ready, out_data);
    end
    #2 rst = 1'b0;
    in_valid = 1'b1; in_data = 160'h33; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    tests++;
    if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, 160'h33}) begin
      fails++; $display("FAIL post_rst_accept got v=%0b occ=%0d d=%h exp 1 1 33", out_valid, occupancy, out_data);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL post_rst_drain got %0b exp 0", out_valid);
    end
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    int unsigned   seq = 1;
    int            max_occ;
`ifdef PIPE_SKID_STAGE_SKID_EN
    max_occ = 2;
`else
    max_occ = 1;
`endif
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      bubble    = ($urandom_range(0, 7) == 0);
      in_data   = DW'(seq) ^ (DW'(seq) << 96);
      #1;
      tests++;
      if (int'(occupancy) != q.size() || int'(occupancy) > max_occ) begin
        fails++;
        if (fails < 20) $display("FAIL rnd_occ cyc %0d got %0d exp %0d", c, occupancy, q.size());
      end
      if (out_valid && out_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : RST_V;
        tests++;
        if (out_data !== exp_d) begin
          fails++;
          if (fails < 20) $display("FAIL rnd_data cyc %0d got %h exp %h", c, out_data, exp_d);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        seq++;
      end
      step();
    end
    in_valid = 1'b0; bubble = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        exp_d = (q.size() != 0) ? q.pop_front() : RST_V;
        tests++;
        if (out_data !== exp_d) begin
          fails++; $display("FAIL rnd_drain got %h exp %h", out_data, exp_d);
        end
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      fails++; $display("FAIL rnd_final got v=%0b left=%0d exp 0 0", out_valid, q.size());
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_bubble();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
